// File: rtl/result_writeback.sv
// result_writeback: captures accumulator rows during the drain phase, requantizes
// them (arithmetic shift, optional rounding, optional ReLU, signed saturation),
// buffers them in a small first-word-fall-through FIFO and writes them to the
// output SRAM over a valid/ready port.
// Build option: define WB_ROUNDING_EN to round half-up before the shift;
// without it the shift truncates toward -inf.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for tile_start; stray rows set err
// COLLECT | capturing ARRAY_SIZE rows from the controller
// FLUSH   | all rows captured; draining pipe and FIFO to SRAM
// DONE    | one cycle, wb_done asserted
module result_writeback #(
  parameter int ARRAY_SIZE = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int ROW_W      = $clog2(ARRAY_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tile_start,
  input  logic [ADDR_WIDTH-1:0]            cfg_base_addr,
  input  logic [5:0]                       cfg_shift,
  input  logic                             cfg_relu,
  input  logic                             drain_result_en,
  input  logic [ROW_W-1:0]                 drain_row,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  acc_row,
  output logic                             wr_valid,
  input  logic                             wr_ready,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [ARRAY_SIZE*OUT_WIDTH-1:0]  wr_data,
  output logic                             busy,
  output logic                             wb_done,
  output logic                             err
);

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_FLUSH, ST_DONE} state_t;

  localparam int EXT_W = ACC_WIDTH + 1;
  localparam int RC_W  = ROW_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int DW    = ARRAY_SIZE * OUT_WIDTH;
  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  state_t                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          base_q, base_d;
  logic [5:0]                     shift_q, shift_d;
  logic                           relu_q, relu_d;
  logic                           err_q, err_d;
  logic [RC_W-1:0]                cnt_q, cnt_d;
  logic                           s1_valid_q, s1_valid_d;
  logic [ROW_W-1:0]               s1_row_q, s1_row_d;
  logic [ARRAY_SIZE*ACC_WIDTH-1:0] s1_acc_q, s1_acc_d;
  logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FC_W-1:0]                fcnt_q, fcnt_d;
  logic [DW-1:0]                  mem_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]          mem_addr_q [FIFO_DEPTH];

  logic          fifo_empty, fifo_full, push, pop, capture;
  logic [DW-1:0] q_data;

  // Per-element requantization of the row sitting in stage 1
  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_quant
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] shifted;
    always_comb begin
      ext = {s1_acc_q[gi*ACC_WIDTH+ACC_WIDTH-1], s1_acc_q[gi*ACC_WIDTH +: ACC_WIDTH]};
`ifdef WB_ROUNDING_EN
      // One extra bit of headroom means adding the half-LSB can never wrap
      if (shift_q != 6'd0) ext = ext + (EXT_W'(1) << (shift_q - 6'd1));
`endif
      shifted = ext >>> shift_q;
      if (relu_q && shifted[EXT_W-1]) shifted = '0;
      if (shifted > SAT_MAX)      q_data[gi*OUT_WIDTH +: OUT_WIDTH] = SAT_MAX[OUT_WIDTH-1:0];
      else if (shifted < SAT_MIN) q_data[gi*OUT_WIDTH +: OUT_WIDTH] = SAT_MIN[OUT_WIDTH-1:0];
      else                        q_data[gi*OUT_WIDTH +: OUT_WIDTH] = shifted[OUT_WIDTH-1:0];
    end
  end

  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == FC_W'(FIFO_DEPTH));
  assign pop        = !fifo_empty && wr_ready;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign push       = s1_valid_q && (!fifo_full || pop);
  assign capture    = drain_result_en && (state_q == ST_COLLECT);

  // Next-state, config latch, capture stage and FIFO bookkeeping
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    s1_valid_d = capture;
    s1_row_d   = s1_row_q;
    s1_acc_d   = s1_acc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fcnt_d     = fcnt_q + FC_W'(push) - FC_W'(pop);

    if (capture) begin
      s1_row_d = drain_row;
      s1_acc_d = acc_row;
    end

    case (state_q)
      ST_IDLE: begin
        if (tile_start) begin
          state_d = ST_COLLECT;
          base_d  = cfg_base_addr;
          shift_d = (cfg_shift > 6'(ACC_WIDTH-1)) ? 6'(ACC_WIDTH-1) : cfg_shift;
          relu_d  = cfg_relu;
          err_d   = 1'b0;
          cnt_d   = '0;
        end else if (drain_result_en) begin
          err_d = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (capture) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == RC_W'(ARRAY_SIZE-1)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (drain_result_en) err_d = 1'b1;
        if (!s1_valid_q && fifo_empty) state_d = ST_DONE;
      end
      default: begin
        if (drain_result_en) err_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    // Controller cannot stall, so a row that finds the FIFO full is lost
    if (s1_valid_q && !push) err_d = 1'b1;

    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
  end

  // Control and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_row_q   <= '0;
      s1_acc_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_row_q   <= s1_row_d;
      s1_acc_q   <= s1_acc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_data_q[wr_ptr_q] <= q_data;
      mem_addr_q[wr_ptr_q] <= base_q + ADDR_WIDTH'(s1_row_q);
    end
  end

  assign wr_valid = !fifo_empty;
  assign wr_data  = fifo_empty ? '0 : mem_data_q[rd_ptr_q];
  assign wr_addr  = fifo_empty ? '0 : mem_addr_q[rd_ptr_q];
  assign busy     = (state_q == ST_COLLECT) || (state_q == ST_FLUSH);
  assign wb_done  = (state_q == ST_DONE);
  assign err      = err_q;

endmodule

// File: tb/tb_result_writeback.sv
// Bench for result_writeback with ARRAY_SIZE=4 and a two-entry FIFO, so that
// overflow is reachable within one tile. Expected rows go into a queue when
// driven and are matched against SRAM writes as they are accepted.
module tb_result_writeback;

  localparam int AS = 4;
  localparam int AW = 32;
  localparam int OW = 8;
  localparam int FD = 2;
  localparam int ADW = 10;
  localparam int RW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tile_start = 1'b0;
  logic [ADW-1:0]    cfg_base_addr = '0;
  logic [5:0]        cfg_shift = '0;
  logic              cfg_relu = 1'b0;
  logic              drain_result_en = 1'b0;
  logic [RW-1:0]     drain_row = '0;
  logic [AS*AW-1:0]  acc_row = '0;
  logic              wr_valid;
  logic              wr_ready = 1'b1;
  logic [ADW-1:0]    wr_addr;
  logic [AS*OW-1:0]  wr_data;
  logic              busy, wb_done, err;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [ADW-1:0]   addr;
    logic [AS*OW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [ADW-1:0] cur_base;
  int             cur_shift;
  bit             cur_relu;

  result_writeback #(
    .ARRAY_SIZE(AS), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
    .FIFO_DEPTH(FD), .ADDR_WIDTH(ADW), .ROW_W(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tile_start(tile_start),
    .cfg_base_addr(cfg_base_addr), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .drain_result_en(drain_result_en), .drain_row(drain_row), .acc_row(acc_row),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .wb_done(wb_done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [AS*OW-1:0] pk(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [AS*AW-1:0] pa(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [OW-1:0] quant(input int acc, input int sh, input bit relu);
    longint v;
    int s;
    s = (sh > AW-1) ? AW-1 : sh;
    v = longint'(acc);
`ifdef WB_ROUNDING_EN
    if (s > 0) v = v + (longint'(1) << (s-1));
`endif
    v = v >>> s;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[OW-1:0];
  endfunction

  function automatic logic [AS*OW-1:0] model_row(input logic [AS*AW-1:0] a, input int sh, input bit relu);
    logic [AS*OW-1:0] r;
    for (int i = 0; i < AS; i++) r[i*OW +: OW] = quant(int'($signed(a[i*AW +: AW])), sh, relu);
    return r;
  endfunction

  // Scoreboard: every accepted write must match the oldest expected row;
  // a stalled request must hold its address and data
  logic           prev_stall = 1'b0;
  logic [ADW-1:0] prev_addr;
  logic [AS*OW-1:0] prev_data;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && wr_valid) begin
        n_checks++;
        if (wr_addr !== prev_addr || wr_data !== prev_data) begin
          n_fail++;
          $display("FAIL hold: addr %h data %h, required addr %h data %h", wr_addr, wr_data, prev_addr, prev_data);
        end
      end
      if (wr_valid && wr_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr %h data %h, required no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            n_fail++;
            $display("FAIL write: addr %h data %h, required addr %h data %h", wr_addr, wr_data, e.addr, e.data);
          end
        end
      end
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int dn);
    dn = 0;
    repeat (n) begin
      tick();
      if (wb_done) dn++;
    end
  endtask

  task automatic start_tile(input logic [ADW-1:0] base, input int sh, input bit relu);
    cfg_base_addr = base;
    cfg_shift = 6'(sh);
    cfg_relu = relu;
    tile_start = 1'b1;
    tick();
    tile_start = 1'b0;
    cur_base = base;
    cur_shift = sh;
    cur_relu = relu;
  endtask

  task automatic send_row(input int row, input logic [AS*AW-1:0] acc,
                          input logic [AS*OW-1:0] exp_data, input bit keep);
    exp_t e;
    drain_result_en = 1'b1;
    drain_row = RW'(row);
    acc_row = acc;
    if (keep) begin
      e.addr = cur_base + ADW'(row);
      e.data = exp_data;
      exp_q.push_back(e);
    end
    tick();
    drain_result_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || wb_done !== 1'b0 || err !== 1'b0 ||
        wr_addr !== '0 || wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset: valid %b busy %b done %b err %b addr %h data %h, required all 0",
               wr_valid, busy, wb_done, err, wr_addr, wr_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int dn;
    wr_ready = 1'b1;
    start_tile(10'h010, 0, 1'b0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_collect: got %b, required 1", busy); end
    for (int r = 0; r < AS; r++) begin
      drain_result_en = 1'b1;
      send_row(r, pa(4*r+1, 4*r+2, 4*r+3, 4*r+4), pk(4*r+1, 4*r+2, 4*r+3, 4*r+4), 1'b1);
      if (r < AS-1) drain_result_en = 1'b1;
      if (r == 0) begin
        n_checks++;
        if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: wr_valid %b, required 0", wr_valid); end
      end
      if (r == 1) begin
        n_checks++;
        if (wr_valid !== 1'b1 || wr_addr !== 10'h010) begin
          n_fail++;
          $display("FAIL latency: wr_valid %b addr %h, required 1 addr 010", wr_valid, wr_addr);
        end
      end
    end
    drain_result_en = 1'b0;
    run(12, dn);
    n_checks++;
    if (dn !== 1 || err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: wb_done pulses %0d err %b busy %b, required 1 0 0", dn, err, busy);
    end
  endtask

  task automatic test_saturate();
    int dn;
    for (int k = 0; k < 2; k++) begin
      start_tile(10'h020, 0, k[0]);
      for (int r = 0; r < AS; r++)
        send_row(r, pa(300, -300, -5, 127), (k == 0) ? pk(127, -128, -5, 127) : pk(127, 0, 0, 127), 1'b1);
      run(10, dn);
      n_checks++;
      if (dn !== 1 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL saturate_done: relu %0d pulses %0d err %b, required 1 0", k, dn, err);
      end
    end
  endtask

  task automatic test_rounding();
    int dn;
    logic [AS*OW-1:0] e2, e63;
`ifdef WB_ROUNDING_EN
    e2  = pk(2, -1, 2, -2);
    e63 = pk(-1, 1, 0, 0);
`else
    e2  = pk(1, -2, 1, -2);
    e63 = pk(-1, 0, 0, -1);
`endif
    start_tile(10'h030, 2, 1'b0);
    for (int r = 0; r < AS; r++) send_row(r, pa(6, -6, 7, -7), e2, 1'b1);
    run(10, dn);
    // shift 63 clamps to 31
    start_tile(10'h040, 63, 1'b0);
    for (int r = 0; r < AS; r++) send_row(r, pa(32'h8000_0000, 32'h7FFF_FFFF, 5, -1), e63, 1'b1);
    run(10, dn);
    n_checks++;
    if (dn !== 1) begin n_fail++; $display("FAIL round_done: pulses %0d, required 1", dn); end
  endtask

  task automatic test_backpressure();
    int dn;
    start_tile(10'h050, 0, 1'b0);
    wr_ready = 1'b0;
    for (int r = 0; r < AS; r++) send_row(r, pa(r, r+1, r+2, r+3), pk(r, r+1, r+2, r+3), r < FD);
    run(3, dn);
    n_checks++;
    if (err !== 1'b1 || wr_valid !== 1'b1 || wr_addr !== 10'h050 || busy !== 1'b1 || dn !== 0) begin
      n_fail++;
      $display("FAIL overflow: err %b valid %b addr %h busy %b pulses %0d, required 1 1 050 1 0",
               err, wr_valid, wr_addr, busy, dn);
    end
    wr_ready = 1'b1;
    run(10, dn);
    n_checks++;
    if (dn !== 1 || err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_done: pulses %0d err %b busy %b, required 1 1 0", dn, err, busy);
    end
  endtask

  task automatic test_full_push_pop();
    int dn;
    start_tile(10'h060, 1, 1'b1);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b, required 0", err); end
    wr_ready = 1'b0;
    for (int r = 0; r < AS; r++) begin
      logic [AS*AW-1:0] a;
      if (r == 3) wr_ready = 1'b1;
      a = pa(10*r-15, 401, -3, r);
      send_row(r, a, model_row(a, cur_shift, cur_relu), 1'b1);
    end
    run(10, dn);
    n_checks++;
    if (dn !== 1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL push_pop_full: pulses %0d err %b, required 1 0", dn, err);
    end
  endtask

  task automatic test_addr();
    int dn;
    int order [AS] = '{3, 1, 0, 2};
    start_tile(10'h3FE, 0, 1'b0);
    for (int r = 0; r < AS; r++) send_row(r, pa(r, -r, 50, -50), pk(r, -r, 50, -50), 1'b1);
    run(10, dn);
    start_tile(10'h100, 0, 1'b0);
    for (int i = 0; i < AS; i++) begin
      if (i == 2) begin
        tile_start = 1'b1;
        cfg_base_addr = 10'h200;
      end
      send_row(order[i], pa(i, i, i, i), pk(i, i, i, i), 1'b1);
      tile_start = 1'b0;
    end
    run(10, dn);
    n_checks++;
    if (dn !== 1) begin n_fail++; $display("FAIL addr_done: pulses %0d, required 1", dn); end
  endtask

  task automatic test_stray_rows();
    int dn;
    send_row(0, pa(1, 1, 1, 1), '0, 1'b0);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL idle_row_err: got %b, required 1", err); end
    run(3, dn);
    n_checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_row_write: valid %b busy %b, required 0 0", wr_valid, busy);
    end
    start_tile(10'h070, 20, 1'b0);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: err %b busy %b, required 0 1", err, busy);
    end
    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < AS; r++) begin
        logic [AS*AW-1:0] a;
        a = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom, $urandom, $urandom}
                                        : pa(int'($urandom_range(0, 4000000)) - 2000000, -7, 1 << 20, -(1 << 21));
        send_row(r, a, model_row(a, cur_shift, cur_relu), 1'b1);
      end
      // extra row arrives in FLUSH and must be rejected
      send_row(0, pa(9, 9, 9, 9), '0, 1'b0);
      run(10, dn);
      n_checks++;
      if (dn !== 1 || err !== 1'b1) begin
        n_fail++;
        $display("FAIL flush_row: pulses %0d err %b, required 1 1", dn, err);
      end
      if (t == 0) start_tile(10'h080, int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    int dn;
    start_tile(10'h090, 0, 1'b0);
    wr_ready = 1'b0;
    for (int r = 0; r < AS; r++) send_row(r, pa(r, r, r, r), pk(r, r, r, r), r < FD);
    run(2, dn);
    n_checks++;
    if (wr_valid !== 1'b1 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: valid %b err %b, required 1 1", wr_valid, err);
    end
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    n_checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || wb_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: valid %b busy %b err %b done %b, required 0 0 0 0", wr_valid, busy, err, wb_done);
    end
    rst_n = 1'b1;
    wr_ready = 1'b1;
    run(10, dn);
    n_checks++;
    if (dn !== 0 || wr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: pulses %0d valid %b, required 0 0", dn, wr_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_rounding();
    test_backpressure();
    test_full_push_pop();
    test_addr();
    test_stray_rows();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_rows: %0d left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
